// File: rtl/sdram_burst_scheduler_pkg.sv
// Shared types and helpers for the SDRAM burst scheduler: FSM states,
// port indices and the write/read port classification.
package sdram_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT   = 2'd2,
        UPDATE = 2'd3
    } state_t;

    localparam logic [1:0] P_WR1 = 2'd0;
    localparam logic [1:0] P_WR2 = 2'd1;
    localparam logic [1:0] P_RD1 = 2'd2;
    localparam logic [1:0] P_RD2 = 2'd3;

    // Ports 0/1 drain camera FIFOs into SDRAM; ports 2/3 fill TFT read FIFOs.
    function automatic logic is_write(input logic [1:0] idx);
        return (idx < P_RD1);
    endfunction

endpackage

// File: rtl/sdram_burst_scheduler_if.sv
// Burst command channel between the scheduler (master) and the SDRAM
// command core (slave), including the core's burst-complete pulse.
interface sdram_burst_scheduler_if #(
    parameter int ADDR_W = 23,
    parameter int LEN_W  = 9
) ();
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [1:0]        cmd_port;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic              cmd_done;

    modport master (
        output cmd_valid, cmd_write, cmd_port, cmd_addr, cmd_len,
        input  cmd_ready, cmd_done
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_port, cmd_addr, cmd_len,
        output cmd_ready, cmd_done
    );
endinterface

// File: rtl/sdram_burst_scheduler_rr_arb4.sv
// Four-way round-robin arbiter: the search starts at i_ptr and wraps,
// returning a one-hot grant and its index. Purely combinational.
module rr_arb4 (
    input  logic [3:0] i_req,
    input  logic [1:0] i_ptr,
    output logic [3:0] o_gnt,
    output logic [1:0] o_idx,
    output logic       o_any
);
    logic [1:0] w_cand;

    always_comb begin
        o_gnt  = 4'b0000;
        o_idx  = i_ptr;
        o_any  = 1'b0;
        w_cand = i_ptr;
        for (int k = 0; k < 4; k++) begin
            w_cand = i_ptr + 2'(k);
            if (!o_any && i_req[w_cand]) begin
                o_any = 1'b1;
                o_idx = w_cand;
                o_gnt = 4'b0001 << w_cand;
            end
        end
    end
endmodule

// File: rtl/sdram_burst_scheduler.sv
// Picks one FIFO port per SDRAM burst by round-robin over fill-level
// eligibility, issues {dir,port,addr,len} and maintains each port's wrapping address.
module sdram_burst_scheduler
    import sdram_sched_pkg::*;
#(
    parameter int ADDR_W     = 23,
    parameter int LEN_W      = 9,
    parameter int USE_W      = 10,
    parameter int FIFO_DEPTH = 512
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            port_en,
    input  logic [3:0]            port_load,
    input  logic [4*ADDR_W-1:0]   port_base,
    input  logic [4*ADDR_W-1:0]   port_max,
    input  logic [4*LEN_W-1:0]    port_len,
    input  logic [4*USE_W-1:0]    port_use,
    sdram_burst_scheduler_if.master cmd,
    output logic [3:0]            port_done,
    output logic                  busy
);
    localparam int AW1 = ADDR_W + 1;

    state_t            r_state;
    logic [1:0]        r_ptr;
    logic              r_valid;
    logic              r_write;
    logic [1:0]        r_port;
    logic [3:0]        r_gnt;
    logic [ADDR_W-1:0] r_cmd_addr;
    logic [LEN_W-1:0]  r_cmd_len;
    logic [3:0]        r_done;
    logic              r_busy;

    logic [3:0]        w_elig;
    logic [ADDR_W-1:0] w_start [4];
    logic [LEN_W-1:0]  w_blen  [4];
    logic [3:0]        w_gnt;
    logic [1:0]        w_gidx;
    logic              w_any;

    function automatic logic [LEN_W-1:0] clip_len(input logic [LEN_W-1:0] len,
                                                   input logic [AW1-1:0]   room);
        if (room < AW1'(len)) return room[LEN_W-1:0];
        return len;
    endfunction

    for (genvar i = 0; i < 4; i++) begin : g_port
        logic [ADDR_W-1:0] w_base;
        logic [ADDR_W-1:0] w_max;
        logic [LEN_W-1:0]  w_len;
        logic [USE_W-1:0]  w_use;
        logic [AW1-1:0]    w_nxt;
        logic              w_fifo_ok;
        logic [ADDR_W-1:0] r_addr;
        logic              r_pend;

        assign w_base = port_base[i*ADDR_W +: ADDR_W];
        assign w_max  = port_max[i*ADDR_W +: ADDR_W];
        assign w_len  = port_len[i*LEN_W +: LEN_W];
        assign w_use  = port_use[i*USE_W +: USE_W];

        // An address left outside [base,max) by a window change restarts at base.
        assign w_start[i] = (r_addr >= w_base && r_addr < w_max) ? r_addr : w_base;
        assign w_blen[i]  = clip_len(w_len, AW1'(w_max) - AW1'(w_start[i]));

        assign w_fifo_ok = is_write(2'(i)) ? (32'(w_use) >= 32'(w_len))
                                           : (32'(w_use) + 32'(w_len) <= 32'(FIFO_DEPTH));
        // A load arriving this cycle blocks the grant so the burst never uses a stale address.
        assign w_elig[i] = port_en[i] && (w_len != '0) && !r_pend && !port_load[i]
                           && (w_max > w_base) && w_fifo_ok;

        assign w_nxt = AW1'(r_cmd_addr) + AW1'(r_cmd_len);

        always_ff @(posedge clk) begin
            if (reset) begin
                r_addr <= w_base;
                r_pend <= 1'b0;
            end else if (r_state == UPDATE && r_port == 2'(i)) begin
                if (r_pend || port_load[i])   r_addr <= w_base;
                else if (w_nxt >= AW1'(w_max)) r_addr <= w_base;
                else                           r_addr <= w_nxt[ADDR_W-1:0];
                r_pend <= 1'b0;
            end else if (port_load[i]) begin
                if (r_busy && r_port == 2'(i)) r_pend <= 1'b1;
                else                           r_addr <= w_base;
            end
        end
    end

    rr_arb4 u_arb (
        .i_req (w_elig),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_gidx),
        .o_any (w_any)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_ptr      <= 2'd0;
            r_valid    <= 1'b0;
            r_write    <= 1'b0;
            r_port     <= 2'd0;
            r_gnt      <= 4'b0000;
            r_cmd_addr <= '0;
            r_cmd_len  <= '0;
            r_done     <= 4'b0000;
            r_busy     <= 1'b0;
        end else begin
            r_done <= 4'b0000;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_gnt      <= w_gnt;
                        r_port     <= w_gidx;
                        r_write    <= is_write(w_gidx);
                        r_cmd_addr <= w_start[w_gidx];
                        r_cmd_len  <= w_blen[w_gidx];
                        r_valid    <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cmd.cmd_ready) begin
                        r_valid <= 1'b0;
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cmd.cmd_done) begin
                        r_done  <= r_gnt;
                        r_state <= UPDATE;
                    end
                end
                UPDATE: begin
                    r_busy  <= 1'b0;
                    r_ptr   <= r_port + 2'd1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cmd.cmd_valid = r_valid;
    assign cmd.cmd_write = r_write;
    assign cmd.cmd_port  = r_port;
    assign cmd.cmd_addr  = r_cmd_addr;
    assign cmd.cmd_len   = r_cmd_len;
    assign port_done     = r_done;
    assign busy          = r_busy;
endmodule

// File: tb/tb_sdram_burst_scheduler.sv
// Directed bench for the SDRAM burst scheduler: a responding core model,
// a rule-level scheduling model checked every cycle, and literal burst expectations.
module tb_sdram_burst_scheduler;
    localparam int ADDR_W = 23;
    localparam int LEN_W  = 9;
    localparam int USE_W  = 10;
    localparam int DEPTH  = 512;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [3:0] port_en = 4'b0000;
    logic [3:0] port_load = 4'b0000;
    int b_base [4];
    int b_max  [4];
    int b_len  [4];
    int b_use  [4];
    logic [4*ADDR_W-1:0] port_base;
    logic [4*ADDR_W-1:0] port_max;
    logic [4*LEN_W-1:0]  port_len;
    logic [4*USE_W-1:0]  port_use;
    logic [3:0] port_done;
    logic       busy;

    always_comb begin
        port_base = '0;
        port_max  = '0;
        port_len  = '0;
        port_use  = '0;
        for (int i = 0; i < 4; i++) begin
            port_base[i*ADDR_W +: ADDR_W] = ADDR_W'(b_base[i]);
            port_max[i*ADDR_W +: ADDR_W]  = ADDR_W'(b_max[i]);
            port_len[i*LEN_W +: LEN_W]    = LEN_W'(b_len[i]);
            port_use[i*USE_W +: USE_W]    = USE_W'(b_use[i]);
        end
    end

    sdram_burst_scheduler_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) cmd_if ();

    sdram_burst_scheduler #(
        .ADDR_W(ADDR_W), .LEN_W(LEN_W), .USE_W(USE_W), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .port_en   (port_en),
        .port_load (port_load),
        .port_base (port_base),
        .port_max  (port_max),
        .port_len  (port_len),
        .port_use  (port_use),
        .cmd       (cmd_if),
        .port_done (port_done),
        .busy      (busy)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Scheduling model: per-port address, reload-pending, round-robin pointer.
    int m_addr [4];
    bit m_pend [4];
    int m_ptr = 0;
    int outstanding = 0;
    int out_port = 0, out_start = 0, out_len = 0;
    int done_cnt = 0;
    int hs_port [$];
    int hs_addr [$];
    int hs_len  [$];
    int hs_write[$];

    function automatic bit m_elig(input int i);
        bit fifo_ok;
        fifo_ok = (i < 2) ? (b_use[i] >= b_len[i]) : (b_use[i] + b_len[i] <= DEPTH);
        return port_en[i] && b_len[i] != 0 && !m_pend[i] && b_max[i] > b_base[i] && fifo_ok;
    endfunction

    function automatic int m_exp_port();
        for (int k = 0; k < 4; k++)
            if (m_elig((m_ptr + k) % 4)) return (m_ptr + k) % 4;
        return -1;
    endfunction

    function automatic int m_start(input int p);
        if (m_addr[p] < b_base[p] || m_addr[p] >= b_max[p]) return b_base[p];
        return m_addr[p];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_addr[i] = b_base[i];
            m_pend[i] = 1'b0;
        end
        m_ptr = 0;
        outstanding = 0;
    endtask

    // Per-cycle compare against the model, sampled on the falling edge.
    bit hold = 1'b0;
    int h_write, h_port, h_addr, h_len;
    always @(negedge clk) begin
        if (reset) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                chk("hold_valid", int'(cmd_if.cmd_valid), 1);
                chk("hold_write", int'(cmd_if.cmd_write), h_write);
                chk("hold_port",  int'(cmd_if.cmd_port), h_port);
                chk("hold_addr",  int'(cmd_if.cmd_addr), h_addr);
                chk("hold_len",   int'(cmd_if.cmd_len), h_len);
            end
            hold    = cmd_if.cmd_valid && !cmd_if.cmd_ready;
            h_write = int'(cmd_if.cmd_write);
            h_port  = int'(cmd_if.cmd_port);
            h_addr  = int'(cmd_if.cmd_addr);
            h_len   = int'(cmd_if.cmd_len);
            if (cmd_if.cmd_valid && cmd_if.cmd_ready) begin
                int ep, es, el;
                ep = m_exp_port();
                chk("model_port", int'(cmd_if.cmd_port), ep);
                if (ep < 0) ep = int'(cmd_if.cmd_port);
                es = m_start(ep);
                el = (b_len[ep] < b_max[ep] - es) ? b_len[ep] : b_max[ep] - es;
                chk("model_write", int'(cmd_if.cmd_write), (ep < 2) ? 1 : 0);
                chk("model_addr",  int'(cmd_if.cmd_addr), es);
                chk("model_len",   int'(cmd_if.cmd_len), el);
                chk("model_outst", outstanding, 0);
                hs_port.push_back(int'(cmd_if.cmd_port));
                hs_addr.push_back(int'(cmd_if.cmd_addr));
                hs_len.push_back(int'(cmd_if.cmd_len));
                hs_write.push_back(int'(cmd_if.cmd_write));
                outstanding++;
                out_port  = ep;
                out_start = es;
                out_len   = el;
            end
            if (port_done != 4'b0000) begin
                logic [3:0] oh;
                oh = 4'b0001 << out_port;
                chk("done_onehot", int'(port_done), int'(oh));
                chk("done_outst", outstanding, 1);
                if (m_pend[out_port]) m_addr[out_port] = b_base[out_port];
                else if (out_start + out_len >= b_max[out_port]) m_addr[out_port] = b_base[out_port];
                else m_addr[out_port] = out_start + out_len;
                m_pend[out_port] = 1'b0;
                m_ptr = (out_port + 1) % 4;
                outstanding--;
                done_cnt++;
            end
        end
    end

    // SDRAM core stand-in: accept after rdly cycles, finish after ddly more.
    bit core_en = 1'b1;
    int rdly = 2;
    int ddly = 3;
    initial begin
        cmd_if.cmd_ready = 1'b0;
        cmd_if.cmd_done  = 1'b0;
        forever begin
            tick(1);
            if (core_en && !reset && cmd_if.cmd_valid) begin
                tick(rdly);
                cmd_if.cmd_ready = 1'b1;
                tick(1);
                cmd_if.cmd_ready = 1'b0;
                tick(ddly);
                cmd_if.cmd_done = 1'b1;
                tick(1);
                cmd_if.cmd_done = 1'b0;
            end
        end
    end

    task automatic wait_hs(input int n, input string name);
        int t = 0;
        while (hs_port.size() < n && t < 2000) begin
            tick(1);
            t++;
        end
        chk(name, hs_port.size(), n);
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((busy || outstanding != 0) && t < 500) begin
            tick(1);
            t++;
        end
        chk("idle_reached", int'(busy) + outstanding, 0);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        int n0, d0, t;
        b_base = '{0, 0, 65536, 0};
        b_max  = '{384000, 0, 66560, 0};
        b_len  = '{256, 0, 256, 0};
        b_use  = '{256, 0, 0, 0};
        tick(3);
        chk("rst_valid", int'(cmd_if.cmd_valid), 0);
        chk("rst_busy",  int'(busy), 0);
        chk("rst_done",  int'(port_done), 0);
        chk("rst_addr",  int'(cmd_if.cmd_addr), 0);
        reset = 1'b0;
        model_reset();

        // WR1 alone: two consecutive bursts
        port_en = 4'b0001;
        wait_hs(2, "t1_hs");
        port_en = 4'b0000;
        wait_idle();
        chk("t1_port",  hs_port[0], 0);
        chk("t1_write", hs_write[0], 1);
        chk("t1_addr0", hs_addr[0], 0);
        chk("t1_len0",  hs_len[0], 256);
        chk("t1_addr1", hs_addr[1], 256);

        // Wrap at port_max: load WR1 to 383872 through a temporary base
        b_base[0] = 383872;
        port_load = 4'b0001;
        tick(1);
        port_load = 4'b0000;
        m_addr[0] = 383872;
        b_base[0] = 0;
        tick(1);
        port_en = 4'b0001;
        wait_hs(4, "t2_hs");
        port_en = 4'b0000;
        wait_idle();
        chk("t2_addr",  hs_addr[2], 383872);
        chk("t2_len",   hs_len[2], 128);
        chk("t2_wrap",  hs_addr[3], 0);
        chk("t2_len2",  hs_len[3], 256);

        // Round-robin between WR1 and RD1
        pulse_reset();
        port_en = 4'b0101;
        n0 = hs_port.size();
        wait_hs(n0 + 8, "t3_hs");
        port_en = 4'b0000;
        wait_idle();
        for (int k = 0; k < 8; k++)
            chk($sformatf("t3_rr%0d", k), hs_port[n0 + k], (k % 2 == 1) ? 2 : 0);
        chk("t3_rd_addr0", hs_addr[n0 + 1], 65536);
        chk("t3_rd_addr3", hs_addr[n0 + 7], 66304);
        chk("t3_rd_write", hs_write[n0 + 1], 0);

        // Read eligibility threshold
        b_use[2] = 257;
        port_en = 4'b0100;
        n0 = hs_port.size();
        tick(20);
        chk("t4_nogrant", hs_port.size(), n0);
        chk("t4_novalid", int'(cmd_if.cmd_valid), 0);
        b_use[2] = 256;
        wait_hs(n0 + 1, "t4_hs");
        port_en = 4'b0000;
        wait_idle();
        chk("t4_port",  hs_port[n0], 2);
        chk("t4_write", hs_write[n0], 0);
        chk("t4_addr",  hs_addr[n0], 65536);

        // Reload requested while WR1's burst is in flight
        ddly = 8;
        port_en = 4'b0001;
        n0 = hs_port.size();
        wait_hs(n0 + 1, "t5_hs");
        tick(2);
        port_load = 4'b0001;
        m_pend[0] = 1'b1;
        tick(1);
        port_load = 4'b0000;
        wait_hs(n0 + 2, "t5_hs2");
        port_en = 4'b0000;
        wait_idle();
        ddly = 3;
        chk("t5_addr",   hs_addr[n0], 1024);
        chk("t5_reload", hs_addr[n0 + 1], 0);

        // Reset while a command waits in ISSUE
        core_en = 1'b0;
        port_en = 4'b0001;
        t = 0;
        while (!cmd_if.cmd_valid && t < 50) begin
            tick(1);
            t++;
        end
        chk("t6_valid_seen", int'(cmd_if.cmd_valid), 1);
        tick(3);
        d0 = done_cnt;
        reset = 1'b1;
        tick(1);
        chk("t6_valid", int'(cmd_if.cmd_valid), 0);
        chk("t6_busy",  int'(busy), 0);
        chk("t6_done",  int'(port_done), 0);
        reset = 1'b0;
        model_reset();
        tick(2);
        chk("t6_nodone", done_cnt, d0);
        core_en = 1'b1;
        n0 = hs_port.size();
        wait_hs(n0 + 1, "t6_hs");
        port_en = 4'b0000;
        wait_idle();
        chk("t6_addr_base", hs_addr[n0], 0);
        chk("done_per_cmd", done_cnt, hs_port.size());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
